// File: rtl/lsu_pkg.sv
// lsu_pkg: LSU state encoding, MMIO address and RV32I load/store funct3 codes.
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} lsu_state_t;
  localparam logic [31:0] MMIO_ADDR = 32'h8000_0000;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
endpackage

// File: rtl/lsu_sram.sv
// lsu_sram: 2^DEPTH_LOG2 x 32 array, synchronous read port, byte-enabled write port.
module lsu_sram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [3:0]            wbe,
  input  logic [31:0]           wdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (wbe[i]) mem[waddr][8*i+:8] <= wdata[8*i+:8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit over a private word array; LSU_MMIO_EN maps 0x8000_0000 to gpio_out.
module lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  gpio_out
);
  lsu_state_t state, state_nx;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic        accept, req_mmio, mmio_q, bad_f3, misalign, oor, req_fault;
  logic [31:0] ram_q, src, sh, rext, wrep, merged;
  logic [3:0]  be;
`ifdef LSU_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gpio_out <= 8'h00;
    else if (state == WR && mmio_q) gpio_out <= wdata_q[7:0];
`else
  localparam bit MMIO_EN = 1'b0;
  assign gpio_out = 8'h00;
`endif
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RSP;
  assign accept    = req_valid & req_ready;
  assign req_mmio  = MMIO_EN && req_addr == MMIO_ADDR;
  assign mmio_q    = MMIO_EN && addr_q == MMIO_ADDR;
  assign bad_f3    = req_we ? req_funct3 > F3_W
                            : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misalign  = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign oor       = (req_addr >> (DEPTH_LOG2 + 2)) != 32'd0 && !req_mmio;
  assign req_fault = bad_f3 | misalign | oor;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (req_fault ? RSP : RD) : IDLE;
      RD:      state_nx = we_q ? WR : RSP;
      WR:      state_nx = RSP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  // Read is launched on the accept edge so the word is ready throughout RD and WR.
  lsu_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clk   (clk),
    .re    (accept & ~req_fault & ~req_mmio),
    .raddr (req_addr[DEPTH_LOG2+1:2]),
    .rdata (ram_q),
    .we    (state == WR && !mmio_q),
    .waddr (addr_q[DEPTH_LOG2+1:2]),
    .wbe   (be),
    .wdata (merged)
  );
  assign src  = mmio_q ? {24'd0, gpio_out} : ram_q;
  assign sh   = src >> {addr_q[1:0], 3'b000};
  assign rext = f3_q == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                f3_q == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                f3_q == F3_BU ? {24'd0, sh[7:0]} :
                f3_q == F3_HU ? {16'd0, sh[15:0]} : src;
  assign be   = f3_q[1] ? 4'hF : f3_q[0] ? (addr_q[1] ? 4'hC : 4'h3) : 4'b0001 << addr_q[1:0];
  assign wrep = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  always_comb begin
    merged = ram_q;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i+:8] = wrep[8*i+:8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (accept && req_fault) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b1;
    end else if (state == RD && !we_q) begin
      rsp_rdata <= rext;
      rsp_err   <= 1'b0;
    end else if (state == WR) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: random and directed checks of lsu against a byte-addressed reference memory.
module tb_lsu;
`ifdef LSU_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_ready, rsp_valid, rsp_err;
  logic [2:0] req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, rsp_rdata;
  logic [7:0] gpio_out;
  logic [7:0] mem_b [1024];
  logic [7:0] gpio_m = 8'h00;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  lsu #(.DEPTH_LOG2(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .gpio_out(gpio_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a[31]) return a[1:0] == 2'd0 ? gpio_m : 8'h00;
    return mem_b[a[9:0]];
  endfunction

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    int sz, lat, n;
    logic flt;
    logic [31:0] v, exp_rd;
    sz  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    flt = (we ? f3 > 3'd2 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
          (a % sz != 0) || (a >= 32'd1024 && !(MMIO && a == 32'h8000_0000));
    exp_rd = 32'd0;
    lat = flt ? 1 : we ? 3 : 2;
    if (!flt && !we) begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v |= 32'(rd_byte(a + i)) << (8 * i);
      exp_rd = f3 == 3'd0 ? 32'($signed(v[7:0])) : f3 == 3'd1 ? 32'($signed(v[15:0])) :
               f3 == 3'd4 ? {24'd0, v[7:0]} : f3 == 3'd5 ? {16'd0, v[15:0]} : v;
    end
    if (!flt && we)
      for (int i = 0; i < sz; i++)
        if (a[31]) gpio_m = wd[7:0];
        else mem_b[a[9:0] + 10'(i)] = wd[8*i+:8];
    @(negedge clk);
    check({tag, " idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 8);
    check({tag, " latency"}, n, lat);
    check({tag, " rdata"}, rsp_rdata, exp_rd);
    check({tag, " err"}, rsp_err, flt);
    check({tag, " gpio"}, gpio_out, gpio_m);
  endtask

  initial begin
    int acc, rsps, seen, sz;
    logic [31:0] a, prior;
    logic [2:0] f3;
    repeat (2) @(negedge clk);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    check("rst rsp_err", rsp_err, 0);
    check("rst gpio", gpio_out, 0);
    rst_n = 1'b1;
    check("rst ready", req_ready, 1);
    for (int i = 0; i < 256; i++) xact("init", 1'b1, 3'd2, 32'(i * 4), $urandom);
    xact("sw 10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    xact("lw 10", 1'b0, 3'd2, 32'h10, 32'd0);
    check("lw 10 const", rsp_rdata, 32'hDEADBEEF);
    xact("sb 13", 1'b1, 3'd0, 32'h13, 32'h11);
    xact("lb 13", 1'b0, 3'd0, 32'h13, 32'd0);
    check("lb 13 const", rsp_rdata, 32'h00000011);
    xact("lw 10b", 1'b0, 3'd2, 32'h10, 32'd0);
    check("lw 10b const", rsp_rdata, 32'h11ADBEEF);
    xact("sb 12", 1'b1, 3'd0, 32'h12, 32'h80);
    xact("lb 12", 1'b0, 3'd0, 32'h12, 32'd0);
    check("lb 12 const", rsp_rdata, 32'hFFFFFF80);
    xact("lbu 12", 1'b0, 3'd4, 32'h12, 32'd0);
    check("lbu 12 const", rsp_rdata, 32'h00000080);
    xact("lh 11", 1'b0, 3'd1, 32'h11, 32'd0);
    xact("sw 12", 1'b1, 3'd2, 32'h12, 32'h12345678);
    xact("lw 400", 1'b0, 3'd2, 32'h400, 32'd0);
    xact("f3 3", 1'b0, 3'd3, 32'h10, 32'd0);
    xact("sw f3 5", 1'b1, 3'd5, 32'h10, 32'hFFFFFFFF);
    xact("lw 10c", 1'b0, 3'd2, 32'h10, 32'd0);
    check("lw 10c const", rsp_rdata, 32'h1180BEEF);
    xact("sb mmio", 1'b1, 3'd0, 32'h8000_0000, 32'h5A);
    check("gpio const", gpio_out, MMIO ? 8'h5A : 8'h00);
    xact("lbu mmio", 1'b0, 3'd4, 32'h8000_0000, 32'd0);
    check("lbu mmio const", rsp_rdata, MMIO ? 32'h5A : 32'h0);
    check("lbu mmio err", rsp_err, !MMIO);
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      case ($urandom_range(0, 19))
        0: a = 32'h8000_0000;
        1: a = 32'h400 + $urandom_range(0, 32'hFFF);
        default: a = $urandom_range(0, 1023);
      endcase
      if ($urandom_range(0, 3) != 0) a &= ~32'(sz - 1);
      xact("rand", 1'($urandom), f3, a, $urandom);
    end
    prior = {mem_b[35], mem_b[34], mem_b[33], mem_b[32]};
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    gpio_m = 8'h00;
    #1 check("abort rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    check("abort no rsp", seen, 0);
    xact("abort lw 20", 1'b0, 3'd2, 32'h20, 32'd0);
    check("abort lw 20 prior", rsp_rdata, prior);
    acc = 0; rsps = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rsps += int'(rsp_valid);
      acc += int'(req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rsps += int'(rsp_valid);
    end
    check("held accepts", acc, 10);
    check("held rsp per accept", rsps, acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
